// File: rtl/key_expansion.sv
// Expands a 32-bit seed into a 512-bit key, one word per clock (word 0 = seed).
// Define KEY_EXP_NLIN_EN to add the nonlinear half-word AND term to the recurrence.
module key_expansion #(
    parameter int SEED_W = 32,
    parameter int KEY_W  = 512,
    parameter int ROT    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEED_W-1:0] seed,
    input  logic              seed_valid,
    output logic              seed_ready,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              busy
);

    localparam int NWORDS = KEY_W / SEED_W;
    localparam int HALF   = SEED_W / 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [SEED_W-1:0] prev_q, prev_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic [SEED_W-1:0] rot_w, word_w;

    assign rot_w = {prev_q[SEED_W-1-ROT:0], prev_q[SEED_W-1:SEED_W-ROT]};

`ifdef KEY_EXP_NLIN_EN
    assign word_w = rot_w ^ SEED_W'(cnt_q)
                  ^ {{HALF{1'b0}}, prev_q[SEED_W-1:HALF] & prev_q[HALF-1:0]};
`else
    assign word_w = rot_w ^ SEED_W'(cnt_q);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        case (state_q)
            S_IDLE: begin
                if (seed_valid) begin
                    key_d   = KEY_W'(seed);
                    prev_d  = seed;
                    cnt_d   = 4'd1;
                    state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                for (int i = 1; i < NWORDS; i++) begin
                    if (cnt_q == 4'(i)) key_d[i*SEED_W +: SEED_W] = word_w;
                end
                prev_d = word_w;
                cnt_d  = cnt_q + 4'd1;
                // Last word written: leave EXPAND before the 4-bit counter wraps.
                if (cnt_q == 4'(NWORDS - 1)) begin
                    cnt_d       = 4'd0;
                    key_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (key_ready) begin
                    key_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                key_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            prev_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign seed_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign key        = key_q;
    assign key_valid  = key_valid_q;

endmodule
